// File: rtl/operand_read_stage.sv
// Operand read stage: takes an issued uop, reads the register file, forwards result-bus values, emits an EX uop.
// Optional feature macro OPREAD_FWD_CNT_EN adds OUT_fwdCount, a count of operands sourced from result buses.

package operand_read_stage_pkg;
   localparam int SQN_W = 16;
   localparam int TAG_W = 7;

   typedef logic [SQN_W-1:0] SqN;
   typedef logic [TAG_W-1:0] Tag;

   typedef struct packed {
      logic [31:0] imm;
      logic [11:0] imm12;
      logic [5:0]  opcode;
      Tag          tagA;
      Tag          tagB;
      Tag          tagDst;
      SqN          sqN;
      logic [4:0]  fetchID;
      logic [2:0]  fetchOffs;
      SqN          storeSqN;
      SqN          loadSqN;
      logic [3:0]  fu;
      logic        compressed;
   } IS_UOp;

   typedef struct packed {
      logic [31:0] srcA;
      logic [31:0] srcB;
      logic [31:0] imm;
      logic [11:0] imm12;
      logic [5:0]  opcode;
      Tag          tagDst;
      SqN          sqN;
      logic [4:0]  fetchID;
      logic [2:0]  fetchOffs;
      SqN          storeSqN;
      SqN          loadSqN;
      logic [3:0]  fu;
      logic        compressed;
   } EX_UOp;

   typedef struct packed {
      Tag          tagDst;
      logic [31:0] result;
   } RES_UOp;

   typedef struct packed {
      logic taken;
      SqN   sqN;
   } BranchProv;

   typedef struct packed {
      logic        hit;
      logic [31:0] value;
   } FwdHit;
endpackage

module operand_read_stage
   import operand_read_stage_pkg::*;
#(
   parameter int RESULT_BUS_COUNT = 4,
   parameter int NUM_OPERANDS     = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              IN_stall,
   output logic                              OUT_stall,
   input  BranchProv                         IN_branch,
   input  logic                              IN_uopValid,
   input  IS_UOp                             IN_uop,
   output logic [1:0]                        OUT_rfReadValid,
   output logic [1:0][5:0]                   OUT_rfReadAddr,
   input  logic [1:0][31:0]                  IN_rfReadData,
   input  logic [RESULT_BUS_COUNT-1:0]       IN_resultValid,
   input  RES_UOp [RESULT_BUS_COUNT-1:0]     IN_resultUOp,
   output logic                              OUT_valid,
   output EX_UOp                             OUT_uop
`ifdef OPREAD_FWD_CNT_EN
   ,
   output logic [31:0]                       OUT_fwdCount
`endif
);

   localparam logic [1:0] USE_OP = (NUM_OPERANDS > 1) ? 2'b11 : 2'b01;

   // Wrap-around age compare: a is younger than b when the signed difference is positive.
   function automatic logic isYounger(input SqN a, input SqN b);
      SqN diff;
      diff = a - b;
      return $signed(diff) > 0;
   endfunction

   function automatic logic isKilled(input SqN s, input BranchProv br);
      return br.taken && isYounger(s, br.sqN);
   endfunction

   function automatic FwdHit findBus(input Tag tag,
                                     input logic [RESULT_BUS_COUNT-1:0] busValid,
                                     input RES_UOp [RESULT_BUS_COUNT-1:0] busUop);
      FwdHit h;
      h = '0;
      // Scan downwards so the lowest matching bus index is the one that sticks.
      for (int j = RESULT_BUS_COUNT - 1; j >= 0; j--) begin
         if (busValid[j] && !tag[6] && busUop[j].tagDst == tag) begin
            h.hit   = 1'b1;
            h.value = busUop[j].result;
         end
      end
      return h;
   endfunction

   function automatic logic [31:0] specialValue(input Tag tag);
      return {{26{tag[5]}}, tag[5:0]};
   endfunction

   Tag   [1:0]        inTag;
   Tag   [1:0]        rTag;
   FwdHit [1:0]       accHit;
   FwdHit [1:0]       rHit;
   logic [1:0][31:0]  opVal;
   logic [1:0]        opBus;

   logic              rValid;
   logic              rFirst;
   IS_UOp             rUop;
   logic [1:0]        rFwdPend;
   logic [1:0][31:0]  rFwdVal;
   logic [1:0][31:0]  rSrc;
   logic [1:0]        rSrcBus;

   logic              oValid;
   EX_UOp             oUop;
   EX_UOp             exNext;

   logic              oReady;
   logic              rKill;
   logic              oKill;
   logic              inKill;
   logic              accept;
   logic              rLeave;

   assign inTag = {IN_uop.tagB, IN_uop.tagA};
   assign rTag  = {rUop.tagB, rUop.tagA};

   assign oReady    = !oValid || !IN_stall;
   assign OUT_stall = rValid && oValid && IN_stall;
   assign inKill    = isKilled(IN_uop.sqN, IN_branch);
   assign rKill     = isKilled(rUop.sqN, IN_branch);
   assign oKill     = isKilled(oUop.sqN, IN_branch);
   assign accept    = IN_uopValid && !OUT_stall && !inKill;
   assign rLeave    = rValid && oReady;

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      OUT_rfReadValid = '0;
      OUT_rfReadAddr  = '0;
      accHit          = '0;
      for (int k = 0; k < 2; k++) begin
         if (USE_OP[k]) begin
            OUT_rfReadValid[k] = IN_uopValid && !inTag[k][6];
            OUT_rfReadAddr[k]  = inTag[k][5:0];
            accHit[k]          = findBus(inTag[k], IN_resultValid, IN_resultUOp);
         end
      end
   end

   // First R cycle resolves operands; afterwards the frozen copy is used with no further snooping.
   always_comb begin
      opVal = '0;
      opBus = '0;
      rHit  = '0;
      for (int k = 0; k < 2; k++) begin
         if (USE_OP[k]) begin
            rHit[k] = findBus(rTag[k], IN_resultValid, IN_resultUOp);
            if (!rFirst) begin
               opVal[k] = rSrc[k];
               opBus[k] = rSrcBus[k];
            end else if (rTag[k][6]) begin
               opVal[k] = specialValue(rTag[k]);
            end else if (rHit[k].hit) begin
               opVal[k] = rHit[k].value;
               opBus[k] = 1'b1;
            end else if (rFwdPend[k]) begin
               opVal[k] = rFwdVal[k];
               opBus[k] = 1'b1;
            end else begin
               opVal[k] = IN_rfReadData[k];
            end
         end
      end
   end

   always_comb begin
      exNext            = '0;
      exNext.srcA       = opVal[0];
      exNext.srcB       = opVal[1];
      exNext.imm        = rUop.imm;
      exNext.imm12      = rUop.imm12;
      exNext.opcode     = rUop.opcode;
      exNext.tagDst     = rUop.tagDst;
      exNext.sqN        = rUop.sqN;
      exNext.fetchID    = rUop.fetchID;
      exNext.fetchOffs  = rUop.fetchOffs;
      exNext.storeSqN   = rUop.storeSqN;
      exNext.loadSqN    = rUop.loadSqN;
      exNext.fu         = rUop.fu;
      exNext.compressed = rUop.compressed;
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         rValid <= 1'b0;
         oValid <= 1'b0;
      end else begin
         if (accept)
            rValid <= 1'b1;
         else if (rLeave || rKill)
            rValid <= 1'b0;

         // A held O entry survives unless the flush kills it, even while stalled.
         if (oValid && IN_stall)
            oValid <= !oKill;
         else
            oValid <= rValid && !rKill;
      end
   end

   // NOTE: payload registers carry no reset; only the valid bits define pipeline state.
   always_ff @(posedge clk) begin
      if (accept) begin
         rUop   <= IN_uop;
         rFirst <= 1'b1;
         for (int k = 0; k < 2; k++) begin
            rFwdPend[k] <= accHit[k].hit;
            rFwdVal[k]  <= accHit[k].value;
         end
      end else if (rFirst) begin
         rFirst  <= 1'b0;
         rSrc    <= opVal;
         rSrcBus <= opBus;
      end

      if (oReady)
         oUop <= exNext;
   end

   assign OUT_valid = oValid;
   assign OUT_uop   = oUop;

`ifdef OPREAD_FWD_CNT_EN
   logic [31:0] fwdCount;

   always_ff @(posedge clk) begin
      if (rst)
         fwdCount <= '0;
      else if (rLeave && !rKill)
         fwdCount <= fwdCount + 32'(opBus[0]) + 32'(opBus[1]);
   end

   assign OUT_fwdCount = fwdCount;
`endif

endmodule

// File: tb/tb_operand_read_stage.sv
// Directed self-checking bench for operand_read_stage: RF read, forwarding, special tags, stall, flush, reset.
// Drives inputs 1 time unit after the rising edge and samples outputs after a further settle delay.

module tb_operand_read_stage;
   import operand_read_stage_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 IN_stall;
   logic                 OUT_stall;
   BranchProv            IN_branch;
   logic                 IN_uopValid;
   IS_UOp                IN_uop;
   logic [1:0]           OUT_rfReadValid;
   logic [1:0][5:0]      OUT_rfReadAddr;
   logic [1:0][31:0]     IN_rfReadData;
   logic [3:0]           IN_resultValid;
   RES_UOp [3:0]         IN_resultUOp;
   logic                 OUT_valid;
   EX_UOp                OUT_uop;
`ifdef OPREAD_FWD_CNT_EN
   logic [31:0]          fwdCount;
`endif

   int errors = 0;
   int checks = 0;
   logic [31:0] rf [64];

   operand_read_stage #(.RESULT_BUS_COUNT(4), .NUM_OPERANDS(2)) dut (
      .clk             (clk),
      .rst             (rst),
      .IN_stall        (IN_stall),
      .OUT_stall       (OUT_stall),
      .IN_branch       (IN_branch),
      .IN_uopValid     (IN_uopValid),
      .IN_uop          (IN_uop),
      .OUT_rfReadValid (OUT_rfReadValid),
      .OUT_rfReadAddr  (OUT_rfReadAddr),
      .IN_rfReadData   (IN_rfReadData),
      .IN_resultValid  (IN_resultValid),
      .IN_resultUOp    (IN_resultUOp),
      .OUT_valid       (OUT_valid),
      .OUT_uop         (OUT_uop)
`ifdef OPREAD_FWD_CNT_EN
      ,
      .OUT_fwdCount    (fwdCount)
`endif
   );

   always #5 clk = ~clk;

   // Register file model: data appears one cycle after the address.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++)
         IN_rfReadData[k] <= rf[OUT_rfReadAddr[k]];
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idleInputs();
      IN_uopValid    = 1'b0;
      IN_uop         = '0;
      IN_stall       = 1'b0;
      IN_branch      = '0;
      IN_resultValid = '0;
      IN_resultUOp   = '0;
   endtask

   task automatic clearBus();
      IN_resultValid = '0;
      IN_resultUOp   = '0;
   endtask

   task automatic setBus(input int j, input Tag tag, input logic [31:0] value);
      IN_resultValid[j]      = 1'b1;
      IN_resultUOp[j].tagDst = tag;
      IN_resultUOp[j].result = value;
   endtask

   function automatic IS_UOp mkUop(input SqN sqN, input Tag a, input Tag b);
      IS_UOp u;
      u            = '0;
      u.imm        = {16'hC0DE, sqN};
      u.imm12      = 12'h5A5 ^ sqN[11:0];
      u.opcode     = 6'h2B;
      u.tagA       = a;
      u.tagB       = b;
      u.tagDst     = 7'h31;
      u.sqN        = sqN;
      u.fetchID    = 5'h13;
      u.fetchOffs  = 3'h6;
      u.storeSqN   = sqN + 16'd3;
      u.loadSqN    = sqN + 16'd7;
      u.fu         = 4'h9;
      u.compressed = sqN[0];
      return u;
   endfunction

   function automatic EX_UOp mkEx(input IS_UOp u, input logic [31:0] a, input logic [31:0] b);
      EX_UOp e;
      e            = '0;
      e.srcA       = a;
      e.srcB       = b;
      e.imm        = u.imm;
      e.imm12      = u.imm12;
      e.opcode     = u.opcode;
      e.tagDst     = u.tagDst;
      e.sqN        = u.sqN;
      e.fetchID    = u.fetchID;
      e.fetchOffs  = u.fetchOffs;
      e.storeSqN   = u.storeSqN;
      e.loadSqN    = u.loadSqN;
      e.fu         = u.fu;
      e.compressed = u.compressed;
      return e;
   endfunction

   task automatic test_reset();
      idleInputs();
      rst      = 1'b1;
      IN_stall = 1'b1;
      step(2);
      checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", OUT_valid); end
      checks++; if (OUT_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", OUT_stall); end
      rst      = 1'b0;
      IN_stall = 1'b0;
      step();
      checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", OUT_valid); end
`ifdef OPREAD_FWD_CNT_EN
      checks++; if (fwdCount !== 32'd0) begin errors++; $display("FAIL reset_fwdcount: got %0d want 0", fwdCount); end
`endif
   endtask

   task automatic test_rf_read();
      IS_UOp u;
      u = mkUop(16'd1, 7'd5, 7'd9);
      IN_uopValid = 1'b1;
      IN_uop      = u;
      #1;
      checks++; if (OUT_rfReadValid !== 2'b11) begin errors++; $display("FAIL rf_read_valid: got %b want 11", OUT_rfReadValid); end
      checks++; if (OUT_rfReadAddr[0] !== 6'd5) begin errors++; $display("FAIL rf_addr_a: got %0d want 5", OUT_rfReadAddr[0]); end
      checks++; if (OUT_rfReadAddr[1] !== 6'd9) begin errors++; $display("FAIL rf_addr_b: got %0d want 9", OUT_rfReadAddr[1]); end
      step();
      IN_uopValid = 1'b0;
      #1;
      checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL rf_latency_t1: got %b want 0", OUT_valid); end
      step();
      checks++; if (OUT_valid !== 1'b1) begin errors++; $display("FAIL rf_latency_t2: got %b want 1", OUT_valid); end
      checks++; if (OUT_uop !== mkEx(u, 32'h11, 32'h22)) begin errors++; $display("FAIL rf_uop: got %h want %h", OUT_uop, mkEx(u, 32'h11, 32'h22)); end
      step();
      checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL rf_drain: got %b want 0", OUT_valid); end
   endtask

   task automatic test_forwarding();
      // Broadcast during the first R cycle; bus 0 and bus 2 both match, bus 0 must win.
      IN_uopValid = 1'b1;
      IN_uop      = mkUop(16'd2, 7'd5, 7'd9);
      step();
      IN_uopValid = 1'b0;
      setBus(0, 7'd5, 32'hAA);
      setBus(2, 7'd5, 32'hCC);
      step();
      clearBus();
      #1;
      checks++; if (OUT_valid !== 1'b1) begin errors++; $display("FAIL fwd_r_valid: got %b want 1", OUT_valid); end
      checks++; if (OUT_uop.srcA !== 32'hAA) begin errors++; $display("FAIL fwd_r_srcA: got %h want 000000aa", OUT_uop.srcA); end
      checks++; if (OUT_uop.srcB !== 32'h22) begin errors++; $display("FAIL fwd_r_srcB: got %h want 00000022", OUT_uop.srcB); end
      step();
      // Broadcast in the acceptance cycle for both operands.
      IN_uopValid = 1'b1;
      IN_uop      = mkUop(16'd3, 7'd5, 7'd9);
      setBus(0, 7'd5, 32'hAA);
      setBus(3, 7'd9, 32'h33);
      step();
      IN_uopValid = 1'b0;
      clearBus();
      step();
      checks++; if (OUT_valid !== 1'b1) begin errors++; $display("FAIL fwd_acc_valid: got %b want 1", OUT_valid); end
      checks++; if (OUT_uop.srcA !== 32'hAA) begin errors++; $display("FAIL fwd_acc_srcA: got %h want 000000aa", OUT_uop.srcA); end
      checks++; if (OUT_uop.srcB !== 32'h33) begin errors++; $display("FAIL fwd_acc_srcB: got %h want 00000033", OUT_uop.srcB); end
      step();
      checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL fwd_drain: got %b want 0", OUT_valid); end
`ifdef OPREAD_FWD_CNT_EN
      checks++; if (fwdCount !== 32'd3) begin errors++; $display("FAIL fwd_count: got %0d want 3", fwdCount); end
`endif
   endtask

   task automatic test_special_tags();
      IN_uopValid = 1'b1;
      IN_uop      = mkUop(16'd4, 7'd5, 7'h7F);
      #1;
      checks++; if (OUT_rfReadValid !== 2'b01) begin errors++; $display("FAIL special_rdvalid_7f: got %b want 01", OUT_rfReadValid); end
      step();
      IN_uop = mkUop(16'd5, 7'h41, 7'h40);
      #1;
      checks++; if (OUT_rfReadValid !== 2'b00) begin errors++; $display("FAIL special_rdvalid_4x: got %b want 00", OUT_rfReadValid); end
      step();
      IN_uopValid = 1'b0;
      #1;
      checks++; if (OUT_uop.srcA !== 32'h11 || OUT_uop.srcB !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL special_7f: got srcA=%h srcB=%h want 00000011 ffffffff", OUT_uop.srcA, OUT_uop.srcB);
      end
      step();
      checks++; if (OUT_valid !== 1'b1 || OUT_uop.srcA !== 32'h1 || OUT_uop.srcB !== 32'h0) begin
         errors++; $display("FAIL special_4x: got v=%b srcA=%h srcB=%h want 1 00000001 00000000", OUT_valid, OUT_uop.srcA, OUT_uop.srcB);
      end
      step();
      checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL special_drain: got %b want 0", OUT_valid); end
   endtask

   task automatic test_back_to_back();
      IS_UOp u [3];
      EX_UOp e [3];
      u[0] = mkUop(16'd40, 7'd5, 7'd9);    e[0] = mkEx(u[0], 32'h11, 32'h22);
      u[1] = mkUop(16'd41, 7'd9, 7'd5);    e[1] = mkEx(u[1], 32'h22, 32'h11);
      u[2] = mkUop(16'd42, 7'h40, 7'd5);   e[2] = mkEx(u[2], 32'h0,  32'h11);
      for (int i = 0; i < 5; i++) begin
         IN_uopValid = (i < 3);
         IN_uop      = (i < 3) ? u[i] : '0;
         #1;
         if (i >= 2) begin
            checks++; if (OUT_valid !== 1'b1 || OUT_uop !== e[i-2]) begin
               errors++; $display("FAIL b2b_%0d: got v=%b %h want 1 %h", i - 2, OUT_valid, OUT_uop, e[i-2]);
            end
         end
         step();
      end
      IN_uopValid = 1'b0;
      #1;
      checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", OUT_valid); end
   endtask

   task automatic test_stall();
      IN_uopValid = 1'b1;
      IN_uop      = mkUop(16'd10, 7'd5, 7'd9);
      step();
      IN_uop      = mkUop(16'd11, 7'd9, 7'd5);
      step();
      IN_uopValid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         IN_stall = 1'b1;
         if (c == 1) begin
            rf[9] = 32'h99;
            setBus(0, 7'd9, 32'hDEAD);
         end else begin
            clearBus();
         end
         #1;
         checks++; if (OUT_valid !== 1'b1 || OUT_uop.sqN !== 16'd10 || OUT_uop.srcA !== 32'h11) begin
            errors++; $display("FAIL stall_hold_%0d: got v=%b sqN=%0d srcA=%h want 1 10 00000011", c, OUT_valid, OUT_uop.sqN, OUT_uop.srcA);
         end
         checks++; if (OUT_stall !== 1'b1) begin errors++; $display("FAIL stall_out_%0d: got %b want 1", c, OUT_stall); end
         step();
      end
      IN_stall = 1'b0;
      clearBus();
      #1;
      checks++; if (OUT_valid !== 1'b1 || OUT_uop.sqN !== 16'd10) begin
         errors++; $display("FAIL stall_release: got v=%b sqN=%0d want 1 10", OUT_valid, OUT_uop.sqN);
      end
      step();
      checks++; if (OUT_valid !== 1'b1 || OUT_uop.sqN !== 16'd11 || OUT_uop.srcA !== 32'h22 || OUT_uop.srcB !== 32'h11) begin
         errors++; $display("FAIL stall_second: got v=%b sqN=%0d srcA=%h srcB=%h want 1 11 00000022 00000011",
                            OUT_valid, OUT_uop.sqN, OUT_uop.srcA, OUT_uop.srcB);
      end
      step();
      checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b want 0", OUT_valid); end
      rf[9] = 32'h22;
   endtask

   // O holds s0, R holds s1, s2 is offered; flush at br while stalled: only s0 survives.
   task automatic flushStalled(input string name, input SqN s0, input SqN s1, input SqN s2, input SqN br);
      IN_uopValid = 1'b1;
      IN_uop      = mkUop(s0, 7'd5, 7'd9);
      step();
      IN_uop      = mkUop(s1, 7'd5, 7'd9);
      step();
      IN_uop          = mkUop(s2, 7'd5, 7'd9);
      IN_stall        = 1'b1;
      IN_branch.taken = 1'b1;
      IN_branch.sqN   = br;
      #1;
      checks++; if (OUT_stall !== 1'b1 || OUT_valid !== 1'b1 || OUT_uop.sqN !== s0) begin
         errors++; $display("FAIL %s_pre: got stall=%b v=%b sqN=%h want 1 1 %h", name, OUT_stall, OUT_valid, OUT_uop.sqN, s0);
      end
      step();
      IN_uopValid = 1'b0;
      IN_branch   = '0;
      #1;
      checks++; if (OUT_valid !== 1'b1 || OUT_uop.sqN !== s0) begin
         errors++; $display("FAIL %s_keep: got v=%b sqN=%h want 1 %h", name, OUT_valid, OUT_uop.sqN, s0);
      end
      checks++; if (OUT_stall !== 1'b0) begin errors++; $display("FAIL %s_rkill: got stall=%b want 0", name, OUT_stall); end
      IN_stall = 1'b0;
      step();
      checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL %s_drop1: got v=%b sqN=%h want 0", name, OUT_valid, OUT_uop.sqN); end
      step();
      checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL %s_drop2: got v=%b sqN=%h want 0", name, OUT_valid, OUT_uop.sqN); end
   endtask

   task automatic test_flush();
      flushStalled("flush_plain", 16'd20, 16'd21, 16'd22, 16'd20);
      flushStalled("flush_wrap", 16'hFFFF, 16'h0001, 16'h0002, 16'hFFFF);
      // A stalled O entry that is younger than the branch must vanish despite the stall.
      IN_uopValid = 1'b1;
      IN_uop      = mkUop(16'd5, 7'd5, 7'd9);
      step();
      IN_uop      = mkUop(16'd6, 7'd5, 7'd9);
      step();
      IN_uopValid     = 1'b0;
      IN_stall        = 1'b1;
      IN_branch.taken = 1'b1;
      IN_branch.sqN   = 16'd4;
      #1;
      checks++; if (OUT_valid !== 1'b1 || OUT_uop.sqN !== 16'd5) begin
         errors++; $display("FAIL flush_okill_pre: got v=%b sqN=%0d want 1 5", OUT_valid, OUT_uop.sqN);
      end
      step();
      IN_branch = '0;
      #1;
      checks++; if (OUT_valid !== 1'b0 || OUT_stall !== 1'b0) begin
         errors++; $display("FAIL flush_okill: got v=%b stall=%b want 0 0", OUT_valid, OUT_stall);
      end
      IN_stall = 1'b0;
      step();
      checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL flush_okill_drain: got %b want 0", OUT_valid); end
   endtask

   task automatic test_reset_mid();
      IN_uopValid = 1'b1;
      IN_uop      = mkUop(16'd30, 7'd5, 7'd9);
      step();
      IN_uop      = mkUop(16'd31, 7'd5, 7'd9);
      step();
      IN_uopValid = 1'b0;
      IN_stall    = 1'b1;
      #1;
      checks++; if (OUT_valid !== 1'b1 || OUT_stall !== 1'b1) begin
         errors++; $display("FAIL rstmid_pre: got v=%b stall=%b want 1 1", OUT_valid, OUT_stall);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checks++; if (OUT_valid !== 1'b0 || OUT_stall !== 1'b0) begin
         errors++; $display("FAIL rstmid_clear: got v=%b stall=%b want 0 0", OUT_valid, OUT_stall);
      end
      IN_stall = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         checks++; if (OUT_valid !== 1'b0) begin errors++; $display("FAIL rstmid_quiet_%0d: got %b want 0", c, OUT_valid); end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++)
         rf[i] = 32'h1000 + i;
      rf[5] = 32'h11;
      rf[9] = 32'h22;
      rst   = 1'b1;
      idleInputs();

      test_reset();
      test_rf_read();
      test_forwarding();
      test_special_tags();
      test_back_to_back();
      test_stall();
      test_flush();
      test_reset_mid();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
